// File: rtl/nvram_upload_if.sv
// HPS ioctl read channel plus core memory fetch port for nvram_upload.
// slave = the upload engine, master = HPS/memory side driving it.
interface nvram_upload_if #(
  parameter int AW = 10
);
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          cpu_pause;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_q;
  logic          mem_valid;
  logic          err;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_q, mem_valid,
    output ioctl_din, ioctl_wait, cpu_pause, mem_rd, mem_addr, err
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_q, mem_valid,
    input  ioctl_din, ioctl_wait, cpu_pause, mem_rd, mem_addr, err
  );
endinterface

// File: rtl/nvram_upload.sv
// Serves HPS ioctl_upload reads of NVRAM over a req/valid memory port.
// Optional NVRAM_UPLOAD_CHECKSUM_EN: a read at addr == SIZE returns the two's-complement byte sum.
//
// state | meaning
// IDLE  | no upload session, CPUs running
// PAUSE | CPUs halted, settling before first fetch; reads are latched as pending
// READY | waiting for an HPS read strobe (or serving a pending one)
// FETCH | memory read in flight, HPS held off with ioctl_wait
module nvram_upload #(
  parameter logic [7:0] INDEX     = 8'd4,
  parameter int         AW        = 10,
  parameter int         SIZE      = 1024,
  parameter int         PAUSE_CYC = 16,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] FILL      = 8'hFF
) (
  input logic           clk_sys,
  input logic           reset,
  nvram_upload_if.slave bus
);
  localparam int TMAX = (PAUSE_CYC > TIMEOUT) ? PAUSE_CYC : TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

  state_t        state;
  logic [CW-1:0] timer;
  logic          pending;
  logic [24:0]   pend_addr;
  logic          active;
  logic          req;
  logic [24:0]   req_addr;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign active   = bus.ioctl_upload && (bus.ioctl_index == INDEX);
  assign req      = pending || bus.ioctl_rd;
  assign req_addr = pending ? pend_addr : bus.ioctl_addr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      pending        <= 1'b0;
      pend_addr      <= '0;
      bus.ioctl_din  <= 8'd0;
      bus.ioctl_wait <= 1'b0;
      bus.cpu_pause  <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.err        <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      sum            <= 8'd0;
`endif
    end else if (!active) begin
      // Session ended (or never started): release CPUs, drop any fetch in flight.
      state          <= IDLE;
      pending        <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      bus.cpu_pause  <= 1'b0;
      bus.mem_rd     <= 1'b0;
    end else begin
      bus.mem_rd <= 1'b0;
      case (state)
        IDLE: begin
          state         <= PAUSE;
          timer         <= CW'(PAUSE_CYC);
          pending       <= 1'b0;
          bus.cpu_pause <= 1'b1;
          bus.err       <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
          sum           <= 8'd0;
`endif
        end

        PAUSE: begin
          if (bus.ioctl_rd && !pending) begin
            pending        <= 1'b1;
            pend_addr      <= bus.ioctl_addr;
            bus.ioctl_wait <= 1'b1;
          end
          if (timer <= CW'(1)) begin
            state <= READY;
            timer <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        READY: begin
          if (req) begin
            pending <= 1'b0;
            if (req_addr < 25'(SIZE)) begin
              bus.mem_addr   <= req_addr[AW-1:0];
              bus.mem_rd     <= 1'b1;
              bus.ioctl_wait <= 1'b1;
              timer          <= CW'(TIMEOUT);
              state          <= FETCH;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            end else if (req_addr == 25'(SIZE)) begin
              bus.ioctl_din  <= 8'd0 - sum;
              bus.ioctl_wait <= 1'b0;
`endif
            end else begin
              bus.ioctl_din  <= FILL;
              bus.ioctl_wait <= 1'b0;
            end
          end
        end

        FETCH: begin
          // Strobes arriving here are a protocol violation and are ignored.
          if (bus.mem_valid) begin
            bus.ioctl_din  <= bus.mem_q;
            bus.ioctl_wait <= 1'b0;
            state          <= READY;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            sum            <= sum + bus.mem_q;
`endif
          end else if (timer <= CW'(1)) begin
            bus.ioctl_din  <= FILL;
            bus.ioctl_wait <= 1'b0;
            bus.err        <= 1'b1;
            state          <= READY;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nvram_upload.sv
// Scoreboard bench for nvram_upload (SIZE=4, memory latency 3).
// Build with or without +define+NVRAM_UPLOAD_CHECKSUM_EN.
module tb_nvram_upload;
  localparam int PAUSE_LAT = 21;   // rd in first PAUSE cycle -> din valid
  localparam int FETCH_LAT = 5;    // 2 + memory latency 3
  localparam int TO_LAT    = 256;  // 1 + TIMEOUT
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  localparam logic [7:0] SUM_EXP = 8'hF6;
`else
  localparam logic [7:0] SUM_EXP = 8'hFF;
`endif

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  nvram_upload_if #(.AW(10)) bus ();
  nvram_upload #(.SIZE(4)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  logic [7:0] mem [0:1023];
  logic       mute = 1'b0;
  int         dly = 0;
  logic [9:0] maddr = '0;
  int         cyc = 0;
  int         rd_cnt = 0;
  int         rd_cyc = 0;

  // memory model: mem_valid three cycles after mem_rd is seen
  always @(posedge clk_sys) begin
    bus.mem_valid <= 1'b0;
    if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        bus.mem_valid <= 1'b1;
        bus.mem_q     <= mem[maddr];
      end
    end
    if (bus.mem_rd && !mute) begin
      dly   <= 2;
      maddr <= bus.mem_addr;
    end
  end

  always @(posedge clk_sys) begin
    if (bus.mem_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Issue one read at the current negedge; exp_rd_dly < 0 means no fetch expected.
  task automatic do_read(input string tag, input logic [24:0] a, input logic [7:0] exp,
                         input int exp_lat, input int exp_rd_dly);
    int lat;
    int rd0;
    int t0;
    logic w1;
    logic [7:0] e;
    exp_q.push_back(exp);
    rd0 = rd_cnt;
    t0  = cyc;
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    w1  = bus.ioctl_wait;
    lat = 1;
    while (bus.ioctl_wait && lat < 400) begin
      @(negedge clk_sys);
      lat++;
    end
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " wait@T+1"}, w1, exp_lat > 1);
    e = exp_q.pop_front();
    chk({tag, " din"}, bus.ioctl_din, e);
    @(negedge clk_sys);
    if (exp_rd_dly < 0) begin
      chk({tag, " mem_rd cnt"}, rd_cnt - rd0, 0);
    end else begin
      chk({tag, " mem_rd cnt"}, rd_cnt - rd0, 1);
      chk({tag, " mem_rd at"}, rd_cyc - t0, exp_rd_dly);
    end
  endtask

  task automatic start_session(input string tag);
    bus.ioctl_index  = 8'd4;
    bus.ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk({tag, " cpu_pause"}, bus.cpu_pause, 1);
    chk({tag, " err clr"}, bus.err, 0);
    chk({tag, " wait"}, bus.ioctl_wait, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " din"}, bus.ioctl_din, 0);
    chk({tag, " wait"}, bus.ioctl_wait, 0);
    chk({tag, " cpu_pause"}, bus.cpu_pause, 0);
    chk({tag, " mem_rd"}, bus.mem_rd, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " err"}, bus.err, 0);
  endtask

  initial begin
    int rd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h5A; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    repeat (3) @(negedge clk_sys);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk_sys);

    // session 1: pending read, out-of-range, boundary, timeout, abort
    start_session("s1");
    do_read("pend rd0", 25'd0, 8'h5A, PAUSE_LAT, 17);
    do_read("oor 11", 25'd11, 8'hFF, 1, -1);
    do_read("oor 1025", 25'd1025, 8'hFF, 1, -1);
    do_read("rd3", 25'd3, 8'h33, FETCH_LAT, 1);
    mute = 1'b1;
    do_read("timeout", 25'd1, 8'hFF, TO_LAT, 1);
    chk("timeout err", bus.err, 1);
    mute = 1'b0;
    do_read("after to", 25'd2, 8'h22, FETCH_LAT, 1);
    chk("err sticky", bus.err, 1);

    bus.ioctl_addr = 25'd1;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    chk("abort mem_rd", bus.mem_rd, 1);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort cpu_pause", bus.cpu_pause, 0);
    chk("abort wait", bus.ioctl_wait, 0);
    chk("abort din", bus.ioctl_din, 8'h22);
    repeat (3) @(negedge clk_sys);
    chk("late valid din", bus.ioctl_din, 8'h22);

    // session 2: checksum over bytes 01..04
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    start_session("s2");
    do_read("s2 rd0", 25'd0, 8'h01, PAUSE_LAT, 17);
    do_read("s2 rd1", 25'd1, 8'h02, FETCH_LAT, 1);
    do_read("s2 rd2", 25'd2, 8'h03, FETCH_LAT, 1);
    do_read("s2 rd3", 25'd3, 8'h04, FETCH_LAT, 1);
    do_read("s2 rd size", 25'd4, SUM_EXP, 1, -1);

    rd0 = rd_cnt;
    bus.ioctl_addr   = 25'd0;
    bus.ioctl_rd     = 1'b1;
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    chk("rd+drop mem_rd", bus.mem_rd, 0);
    chk("rd+drop wait", bus.ioctl_wait, 0);
    chk("rd+drop cpu_pause", bus.cpu_pause, 0);
    @(negedge clk_sys);
    chk("rd+drop rd cnt", rd_cnt - rd0, 0);

    // session 3: reset while fetching
    start_session("s3");
    do_read("s3 rd0", 25'd0, 8'h01, PAUSE_LAT, 17);
    bus.ioctl_addr = 25'd3;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    chk("s3 fetch addr", bus.mem_addr, 3);
    chk("s3 fetch wait", bus.ioctl_wait, 1);
    reset = 1'b1;
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk_reset_vals("rst fetch");
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;

    // wrong index never starts a session
    bus.ioctl_index  = 8'd5;
    bus.ioctl_upload = 1'b1;
    repeat (30) @(negedge clk_sys);
    chk("bad idx cpu_pause", bus.cpu_pause, 0);
    rd0 = rd_cnt;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    repeat (6) @(negedge clk_sys);
    chk("bad idx wait", bus.ioctl_wait, 0);
    chk("bad idx din", bus.ioctl_din, 0);
    chk("bad idx rd cnt", rd_cnt - rd0, 0);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
